mips_dm_arbiter: RTL and testbench

MIPS_DM_ARBITER -- requirements
Module: mips_dm_arbiter

---
 rtl/mips_dm_arbiter_if.sv | 60 ++++++
 rtl/mips_dm_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mips_dm_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_dm_arbiter_if.sv
// Purpose : bundle of the CPU port, DMA port and data-memory port seen by
//           mips_dm_arbiter.
// Modports: slave  - arbiter view (takes requests, drives acks and dm_*)
//           master - environment view (drives requests and memory read data)
// Signals : cpu_*/dma_* request fields (req, we, addr, wdata, width, sext),
//           response (ack, rdata, err), cpu_stall, and the dm_* memory bus.
interface mips_dm_arbiter_if;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned WIDTH_W = 2;

   // CPU port
   logic               cpu_req;
   logic               cpu_we;
   logic [DATA_W-1:0]  cpu_addr;
   logic [DATA_W-1:0]  cpu_wdata;
   logic [WIDTH_W-1:0] cpu_width;
   logic               cpu_sext;
   logic               cpu_ack;
   logic [DATA_W-1:0]  cpu_rdata;
   logic               cpu_err;
   logic               cpu_stall;

   // DMA port
   logic               dma_req;
   logic               dma_we;
   logic [DATA_W-1:0]  dma_addr;
   logic [DATA_W-1:0]  dma_wdata;
   logic [WIDTH_W-1:0] dma_width;
   logic               dma_sext;
   logic               dma_ack;
   logic [DATA_W-1:0]  dma_rdata;
   logic               dma_err;

   // Data-memory port
   logic [DATA_W-1:0]  dm_addr;
   logic [DATA_W-1:0]  dm_wdata;
   logic               dm_we;
   logic [WIDTH_W-1:0] dm_width;
   logic               dm_sext;
   logic [DATA_W-1:0]  dm_rdata;
   logic               dm_error;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_width, cpu_sext,
      output cpu_ack, cpu_rdata, cpu_err, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata, dma_width, dma_sext,
      output dma_ack, dma_rdata, dma_err,
      output dm_addr, dm_wdata, dm_we, dm_width, dm_sext,
      input  dm_rdata, dm_error
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_width, cpu_sext,
      input  cpu_ack, cpu_rdata, cpu_err, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata, dma_width, dma_sext,
      input  dma_ack, dma_rdata, dma_err,
      input  dm_addr, dm_wdata, dm_we, dm_width, dm_sext,
      output dm_rdata, dm_error
   );
endinterface

// File: rtl/mips_dm_arbiter.sv
// Purpose : two-port (CPU / DMA) arbiter in front of a single data memory.
//           Each transaction takes IDLE (grant) -> ACC (memory cycle) ->
//           RESP (ack). CPU wins contested grants unless DMA has lost
//           STARVE_MAX contested rounds in a row.
// Ports   : clk    - system clock, rising edge
//           reset  - synchronous active-high reset
//           arb_if - slave side of mips_dm_arbiter_if (requests, acks, dm_*)
module mips_dm_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             reset,
   mips_dm_arbiter_if.slave arb_if
);
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned WIDTH_W  = 2;
   localparam int unsigned STARVE_W = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   logic [1:0]          state_q,     state_d;
   logic                owner_q,     owner_d;
   logic [STARVE_W-1:0] starve_q,    starve_d;

   // dm_* registers double as the latched request fields for the ACC cycle
   logic                dm_we_q,     dm_we_d;
   logic [DATA_W-1:0]   dm_addr_q,   dm_addr_d;
   logic [DATA_W-1:0]   dm_wdata_q,  dm_wdata_d;
   logic [WIDTH_W-1:0]  dm_width_q,  dm_width_d;
   logic                dm_sext_q,   dm_sext_d;

   logic                cpu_ack_q,   cpu_ack_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic                cpu_err_q,   cpu_err_d;
   logic                dma_ack_q,   dma_ack_d;
   logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
   logic                dma_err_q,   dma_err_d;

   logic                starve_hit_c;
   logic                grant_dma_c;

   // DMA wins when it is alone or when it has been passed over too often
   assign starve_hit_c = (starve_q == STARVE_W'(STARVE_MAX));
   assign grant_dma_c  = arb_if.dma_req & (~arb_if.cpu_req | starve_hit_c);

   // Next-state and output decode
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      starve_d    = starve_q;
      dm_we_d     = 1'b0;
      dm_addr_d   = '0;
      dm_wdata_d  = '0;
      dm_width_d  = '0;
      dm_sext_d   = 1'b0;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      cpu_err_d   = cpu_err_q;
      dma_rdata_d = dma_rdata_q;
      dma_err_d   = dma_err_q;

      case (state_q)
         ST_IDLE: begin
            if (!arb_if.dma_req) begin
               starve_d = '0;
            end
            if (arb_if.cpu_req || arb_if.dma_req) begin
               state_d = ST_ACC;
               if (grant_dma_c) begin
                  owner_d    = OWN_DMA;
                  starve_d   = '0;
                  dm_we_d    = arb_if.dma_we;
                  dm_addr_d  = arb_if.dma_addr;
                  dm_wdata_d = arb_if.dma_wdata;
                  dm_width_d = arb_if.dma_width;
                  dm_sext_d  = arb_if.dma_sext;
               end else begin
                  owner_d    = OWN_CPU;
                  // count only contested CPU wins; saturate at the limit
                  if (arb_if.dma_req && !starve_hit_c) begin
                     starve_d = starve_q + STARVE_W'(1);
                  end
                  dm_we_d    = arb_if.cpu_we;
                  dm_addr_d  = arb_if.cpu_addr;
                  dm_wdata_d = arb_if.cpu_wdata;
                  dm_width_d = arb_if.cpu_width;
                  dm_sext_d  = arb_if.cpu_sext;
               end
            end
         end

         ST_ACC: begin
            // memory read is combinational: capture it at the end of ACC
            state_d = ST_RESP;
            if (owner_q == OWN_DMA) begin
               dma_ack_d   = 1'b1;
               dma_rdata_d = arb_if.dm_rdata;
               dma_err_d   = arb_if.dm_error;
            end else begin
               cpu_ack_d   = 1'b1;
               cpu_rdata_d = arb_if.dm_rdata;
               cpu_err_d   = arb_if.dm_error;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_CPU;
         starve_q    <= '0;
         dm_we_q     <= 1'b0;
         dm_addr_q   <= '0;
         dm_wdata_q  <= '0;
         dm_width_q  <= '0;
         dm_sext_q   <= 1'b0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         cpu_err_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         dma_rdata_q <= '0;
         dma_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         starve_q    <= starve_d;
         dm_we_q     <= dm_we_d;
         dm_addr_q   <= dm_addr_d;
         dm_wdata_q  <= dm_wdata_d;
         dm_width_q  <= dm_width_d;
         dm_sext_q   <= dm_sext_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_err_q   <= cpu_err_d;
         dma_ack_q   <= dma_ack_d;
         dma_rdata_q <= dma_rdata_d;
         dma_err_q   <= dma_err_d;
      end
   end

   assign arb_if.dm_we     = dm_we_q;
   assign arb_if.dm_addr   = dm_addr_q;
   assign arb_if.dm_wdata  = dm_wdata_q;
   assign arb_if.dm_width  = dm_width_q;
   assign arb_if.dm_sext   = dm_sext_q;
   assign arb_if.cpu_ack   = cpu_ack_q;
   assign arb_if.cpu_rdata = cpu_rdata_q;
   assign arb_if.cpu_err   = cpu_err_q;
   assign arb_if.dma_ack   = dma_ack_q;
   assign arb_if.dma_rdata = dma_rdata_q;
   assign arb_if.dma_err   = dma_err_q;

   // CPU is frozen from request until the ack cycle
   assign arb_if.cpu_stall = arb_if.cpu_req & ~cpu_ack_q;
endmodule

// File: tb/tb_mips_dm_arbiter.sv
// Purpose : self-checking bench for mips_dm_arbiter. A transaction-level
//           model schedules each grant as (access at +1, ack at +2, free at
//           +3) and predicts every output every cycle; a small memory array
//           serves the dm_* port.
module tb_mips_dm_arbiter;
   localparam int unsigned STARVE_MAX  = 4;
   localparam int unsigned RAND_CYCLES = 3000;

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  width;
      logic        sext;
   } port_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mips_dm_arbiter_if arb_if();

   mips_dm_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk    (clk),
      .reset  (reset),
      .arb_if (arb_if.slave)
   );

   // Data memory: 16 words, combinational read, write on clock edge
   logic [31:0] tb_mem [16];
   logic        pre_we;
   logic [3:0]  pre_idx;
   logic [31:0] pre_val;

   assign arb_if.dm_rdata = tb_mem[arb_if.dm_addr[5:2]];
   assign arb_if.dm_error = &arb_if.dm_addr[7:6];

   always @(posedge clk) begin
      if (pre_we) tb_mem[pre_idx] <= pre_val;
      else if (arb_if.dm_we) tb_mem[arb_if.dm_addr[5:2]] <= arb_if.dm_wdata;
   end

   // Bench state
   int    n_chk = 0;
   int    n_pass = 0;
   int    cyc = 0;
   port_t stg [2];
   port_t app [2];
   logic  rst_stg;
   logic  app_rst;
   bit    keep [2];
   bit    ack_prev [2];
   bit    rand_mode = 1'b0;

   // Reference model
   logic [31:0] model_mem [16];
   bit          g_valid = 1'b0;
   int          g_cyc = 0;
   int          g_own = 0;
   port_t       g_req;
   int          next_free = 0;
   int          lost = 0;
   logic [31:0] cap_rdata = '0;
   logic        cap_err = 1'b0;
   logic [31:0] hold_rdata [2];
   logic        hold_err [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [31:0] rand_addr();
      return 32'($urandom_range(0, 63)) << 2;
   endfunction

   function automatic port_t rand_port();
      port_t r;
      r.req   = 1'b1;
      r.we    = 1'($urandom_range(0, 1));
      r.addr  = rand_addr();
      r.wdata = $urandom();
      r.width = 2'($urandom_range(0, 3));
      r.sext  = 1'($urandom_range(0, 1));
      return r;
   endfunction

   function automatic port_t mk_port(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      port_t r;
      r.req   = 1'b1;
      r.we    = we;
      r.addr  = addr;
      r.wdata = wdata;
      r.width = 2'd2;
      r.sext  = 1'b0;
      return r;
   endfunction

   task automatic rand_policy();
      for (int p = 0; p < 2; p++) begin
         if (stg[p].req) begin
            if (ack_prev[p]) begin
               if ($urandom_range(0, 3) == 0) stg[p] = rand_port();
               else stg[p].req = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               stg[p].addr  = rand_addr();
               stg[p].wdata = $urandom();
            end
         end else if ($urandom_range(0, 2) == 0) begin
            stg[p] = rand_port();
         end
      end
      rst_stg = ($urandom_range(0, 149) == 0);
   endtask

   task automatic drive();
      app[0]  = stg[0];
      app[1]  = stg[1];
      app_rst = rst_stg;
      reset             = app_rst;
      arb_if.cpu_req    = app[0].req;
      arb_if.cpu_we     = app[0].we;
      arb_if.cpu_addr   = app[0].addr;
      arb_if.cpu_wdata  = app[0].wdata;
      arb_if.cpu_width  = app[0].width;
      arb_if.cpu_sext   = app[0].sext;
      arb_if.dma_req    = app[1].req;
      arb_if.dma_we     = app[1].we;
      arb_if.dma_addr   = app[1].addr;
      arb_if.dma_wdata  = app[1].wdata;
      arb_if.dma_width  = app[1].width;
      arb_if.dma_sext   = app[1].sext;
   endtask

   // Compare every output of the current cycle against the model
   task automatic check_cycle();
      bit          in_acc;
      bit          in_resp;
      logic        e_ack [2];
      port_t       e_dm;
      in_acc  = g_valid && (cyc == g_cyc + 1);
      in_resp = g_valid && (cyc == g_cyc + 2);
      e_dm    = '{1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0};
      if (in_acc) e_dm = g_req;
      e_ack[0] = in_resp && (g_own == 0);
      e_ack[1] = in_resp && (g_own == 1);
      if (in_resp) begin
         hold_rdata[g_own] = cap_rdata;
         hold_err[g_own]   = cap_err;
      end
      chk("dm_we",     32'(arb_if.dm_we),    32'(e_dm.we));
      chk("dm_addr",   arb_if.dm_addr,       e_dm.addr);
      chk("dm_wdata",  arb_if.dm_wdata,      e_dm.wdata);
      chk("dm_width",  32'(arb_if.dm_width), 32'(e_dm.width));
      chk("dm_sext",   32'(arb_if.dm_sext),  32'(e_dm.sext));
      chk("cpu_ack",   32'(arb_if.cpu_ack),  32'(e_ack[0]));
      chk("dma_ack",   32'(arb_if.dma_ack),  32'(e_ack[1]));
      chk("cpu_rdata", arb_if.cpu_rdata,     hold_rdata[0]);
      chk("dma_rdata", arb_if.dma_rdata,     hold_rdata[1]);
      chk("cpu_err",   32'(arb_if.cpu_err),  32'(hold_err[0]));
      chk("dma_err",   32'(arb_if.dma_err),  32'(hold_err[1]));
      chk("cpu_stall", 32'(arb_if.cpu_stall), 32'(app[0].req & ~e_ack[0]));
      ack_prev[0] = arb_if.cpu_ack;
      ack_prev[1] = arb_if.dma_ack;
   endtask

   // Advance the transaction model by one cycle using the applied inputs
   task automatic model_update();
      bit win_dma;
      if (g_valid && (cyc == g_cyc + 1)) begin
         cap_rdata = model_mem[g_req.addr[5:2]];
         cap_err   = &g_req.addr[7:6];
         if (g_req.we) model_mem[g_req.addr[5:2]] = g_req.wdata;
      end
      if (g_valid && (cyc == g_cyc + 2)) g_valid = 1'b0;
      if (app_rst) begin
         g_valid       = 1'b0;
         lost          = 0;
         hold_rdata[0] = '0;
         hold_rdata[1] = '0;
         hold_err[0]   = 1'b0;
         hold_err[1]   = 1'b0;
         next_free     = cyc + 1;
      end else if (cyc >= next_free) begin
         if (app[0].req || app[1].req) begin
            win_dma   = app[1].req && (!app[0].req || lost == int'(STARVE_MAX));
            g_valid   = 1'b1;
            g_cyc     = cyc;
            g_own     = win_dma ? 1 : 0;
            g_req     = win_dma ? app[1] : app[0];
            next_free = cyc + 3;
            if (win_dma) lost = 0;
            else if (app[1].req) lost = (lost < int'(STARVE_MAX)) ? lost + 1 : lost;
            else lost = 0;
         end else begin
            lost = 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_mode) begin
         rand_policy();
      end else begin
         for (int p = 0; p < 2; p++)
            if (ack_prev[p] && !keep[p]) stg[p].req = 1'b0;
      end
      drive();
      @(negedge clk);
      check_cycle();
      model_update();
      cyc++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int          n_ack;
      logic [9:0]  seq;
      logic [9:0]  exp_seq;

      stg[0] = '{1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0};
      stg[1] = stg[0];
      keep[0] = 1'b0;
      keep[1] = 1'b0;
      ack_prev[0] = 1'b0;
      ack_prev[1] = 1'b0;
      hold_rdata[0] = '0;
      hold_rdata[1] = '0;
      hold_err[0] = 1'b0;
      hold_err[1] = 1'b0;
      rst_stg = 1'b1;
      pre_we  = 1'b0;
      pre_idx = '0;
      pre_val = '0;
      drive();

      // Preload memory while reset is held
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         pre_we  = 1'b1;
         pre_idx = 4'(i);
         pre_val = (i == 4) ? 32'hDEADBEEF : $urandom();
         model_mem[i] = pre_val;
      end
      @(posedge clk);
      #1;
      pre_we = 1'b0;

      steps(2);
      rst_stg = 1'b0;
      steps(2);

      // CPU load from 0x10
      stg[0] = mk_port(1'b0, 32'h10, 32'h0);
      steps(5);

      // DMA store alone
      stg[1] = mk_port(1'b1, 32'h20, 32'h12345678);
      steps(5);

      // DMA access with memory error, then a clean one
      stg[1] = mk_port(1'b0, 32'hC0, 32'h0);
      steps(5);
      stg[1] = mk_port(1'b0, 32'h20, 32'h0);
      steps(5);

      // CPU address changes during the access cycle
      stg[0] = mk_port(1'b0, 32'h10, 32'h0);
      step();
      stg[0].addr = 32'h40;
      steps(5);

      // Reset during ACC of a CPU store
      stg[0] = mk_port(1'b1, 32'h30, 32'hCAFEF00D);
      step();
      rst_stg = 1'b1;
      step();
      rst_stg = 1'b0;
      stg[0].req = 1'b0;
      steps(5);

      // Both requesting continuously: starvation ordering
      rst_stg = 1'b1;
      step();
      rst_stg = 1'b0;
      keep[0] = 1'b1;
      keep[1] = 1'b1;
      stg[0] = mk_port(1'b0, 32'h04, 32'h0);
      stg[1] = mk_port(1'b0, 32'h08, 32'h0);
      n_ack = 0;
      seq   = '0;
      for (int c = 0; c < 60 && n_ack < 10; c++) begin
         step();
         if (arb_if.cpu_ack || arb_if.dma_ack) begin
            seq[n_ack] = arb_if.dma_ack;
            n_ack++;
         end
      end
      for (int i = 0; i < 10; i++)
         exp_seq[i] = (((i + 1) % (int'(STARVE_MAX) + 1)) == 0);
      chk("grant_count", 32'(n_ack), 32'd10);
      chk("grant_order", 32'(seq), 32'(exp_seq));
      keep[0] = 1'b0;
      keep[1] = 1'b0;
      stg[0].req = 1'b0;
      stg[1].req = 1'b0;
      steps(5);

      // Randomized traffic with occasional resets
      rand_mode = 1'b1;
      steps(RAND_CYCLES);
      rand_mode = 1'b0;
      rst_stg = 1'b0;
      stg[0].req = 1'b0;
      stg[1].req = 1'b0;
      steps(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
